register_file_mp: RTL

- Parametrised successor to the single-port 64-bit RegisterFile: one synchronous write port, two independent registered read ports, and a per-register busy scoreboard.
- Sits between decode and execute in the Tinker core.
- Decode reads both source operands in one cycle and reserves the destination register. Writeback writes the result and releases the reservation.

---
 rtl/register_file_mp.sv | 86 ++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised register file with one write port, two registered read ports
// and a per-register busy scoreboard (reserve at decode, release at writeback).
module register_file_mp #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    output logic              busy_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    output logic              busy_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_count
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt;
    logic              wr_ok, rsv_ok, ok_a, ok_b, nb_a, nb_b;
    logic [DATA_W-1:0] nd_a, nd_b;

    assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !(ZERO_REG != 0 && wr_addr == '0);
    assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < DEPTH_L) && !(ZERO_REG != 0 && rsv_addr == '0);
    assign ok_a   = ({1'b0, rd_addr_a} < DEPTH_L) && !(ZERO_REG != 0 && rd_addr_a == '0);
    assign ok_b   = ({1'b0, rd_addr_b} < DEPTH_L) && !(ZERO_REG != 0 && rd_addr_b == '0);

    // Reserve is applied after release so a same-cycle write+reserve leaves the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    assign nd_a = !ok_a ? '0 : (BYPASS != 0 && wr_ok && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
    assign nd_b = !ok_b ? '0 : (BYPASS != 0 && wr_ok && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
    assign nb_a = ok_a && busy_nxt[rd_addr_a];
    assign nb_b = ok_b && busy_nxt[rd_addr_b];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            busy_a     <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
            busy_b     <= 1'b0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            busy       <= busy_nxt;
            busy_count <= cnt;
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= nd_a;
                busy_a    <= nb_a;
            end
            if (rd_en_b) begin
                rd_data_b <= nd_b;
                busy_b    <= nb_b;
            end
        end
    end
endmodule
